universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port en, input, 1, operation enable.
REQ-005 SHALL have port mode, input, 3, operation select (see Function).
REQ-006 SHALL have port d, input, WIDTH, parallel load data.
REQ-007 SHALL have port sin_r, input, 1, serial data entering bit 0 on shift-left.
REQ-008 SHALL have port sin_l, input, 1, serial data entering bit WIDTH-1 on shift-right.
REQ-009 SHALL have port q, output, WIDTH, register contents.
REQ-010 SHALL have port qbar, output, WIDTH, bitwise complement of q.
REQ-011 SHALL have port sout_l, output, 1, equal to q[WIDTH-1].
REQ-012 SHALL have port sout_r, output, 1, equal to q[0].
REQ-013 SHALL have port co, output, 1, registered one-cycle wrap flag for count modes.

Function
REQ-014 q and co SHALL be registers updated only on rising clk; qbar, sout_l, sout_r SHALL be combinational from q, zero latency.
REQ-015 With en=1, mode SHALL select: 000 hold; 001 load q<=d; 010 shift left q<={q[WIDTH-2:0],sin_r}; 011 shift right q<={sin_l,q[WIDTH-1:1]}.
REQ-016 With en=1, mode SHALL also select: 100 rotate left q<={q[WIDTH-2:0],q[WIDTH-1]}; 101 rotate right q<={q[0],q[WIDTH-1:1]}.
REQ-017 With en=1, mode 110 SHALL count up q<=q+1 modulo 2^WIDTH; mode 111 SHALL count down q<=q-1 modulo 2^WIDTH.
REQ-018 co SHALL be 1 for exactly the cycle after an edge where mode 110 takes q from all-ones to 0, or mode 111 takes q from 0 to all-ones; otherwise 0.
REQ-019 With en=0, q SHALL hold regardless of mode, d, sin_l, sin_r, and co SHALL be 0 next cycle.
REQ-020 Modes 000-101 SHALL drive co to 0 next cycle.
REQ-021 Mode changes SHALL take effect on the very next edge; no pipeline, no multi-cycle operations.
REQ-022 Serial inputs SHALL be sampled only in their own shift mode; ignored otherwise.
REQ-023 Arithmetic SHALL be WIDTH bits wide with carry/borrow discarded except as reported on co.

Reset
REQ-024 rst=1 at a rising edge SHALL force q=0 and co=0, so qbar=all ones, sout_l=0, sout_r=0.
REQ-025 rst SHALL take priority over en and every mode, including mid-count and mid-shift sequences.
REQ-026 Without a rising edge, rst SHALL have no effect (no asynchronous clearing).
REQ-027 After rst deasserts, the first enabled edge SHALL operate on q=0.

Verification (WIDTH=4)
REQ-028 Reset: rst=1 one edge, d=1010, mode=001, en=1 -> q=0000, qbar=1111, co=0.
REQ-029 Load then shift: load 1011; mode 010 sin_r=0 -> 0110; mode 011 sin_l=1 -> 1011; sout_l=1, sout_r=1.
REQ-030 Rotate: load 1000; four mode-100 edges -> 0001,0010,0100,1000; four mode-101 edges return through 0100,0010,0001,1000.
REQ-031 Count wrap: load 1110; mode 110 edges -> 1111 (co=0), 0000 (co=1 one cycle), 0001 (co=0); mode 111 from 0000 -> 1111 with co=1.
REQ-032 Hold/enable: load 0101; en=0 for 3 edges with mode cycling through 001-111 and d=1111 -> q stays 0101, co=0.
REQ-033 Reset mid-count: counting up from 0011, rst=1 at the 2nd edge -> q=0000, co=0; en=1 with mode 110 after release -> 0001.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, parallel load, serial shift, rotate and
// modulo up/down count, with a registered one-cycle wrap flag on co.
module universal_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_l,
    output logic             sout_r,
    output logic             co
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_UP   = 3'b110;
    localparam logic [2:0] MODE_DOWN = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] next_q;
    logic             next_co;

    always_comb begin
        next_q  = q;
        next_co = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: next_q = q;
                MODE_LOAD: next_q = d;
                MODE_SHL:  next_q = {q[WIDTH-2:0], sin_r};
                MODE_SHR:  next_q = {sin_l, q[WIDTH-1:1]};
                MODE_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  next_q = {q[0], q[WIDTH-1:1]};
                MODE_UP: begin
                    next_q  = q + ONE;
                    next_co = (q == {WIDTH{1'b1}});
                end
                MODE_DOWN: begin
                    next_q  = q - ONE;
                    next_co = (q == {WIDTH{1'b0}});
                end
                default: next_q = q;
            endcase
        end
    end

    // State register: reset wins over every enable/mode combination.
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= '0;
            co <= 1'b0;
        end else begin
            q  <= next_q;
            co <= next_co;
        end
    end

    assign qbar   = ~q;
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg at WIDTH=4: directed vector table, a
// between-edge reset sequence, then randomized traffic against a model.
module tb_universal_shift_reg;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         sout_l;
    logic         sout_r;
    logic         co;

    int total = 0;
    int bad   = 0;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l),
        .q(q), .qbar(qbar), .sout_l(sout_l), .sout_r(sout_r), .co(co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] d;
        logic         sin_r;
        logic         sin_l;
        logic [W-1:0] exp_q;
        logic         exp_co;
    } vec_t;

    vec_t vecs[$];

    // Reference state for the random phase.
    int mq;
    int mco;

    task automatic check(input string name, input logic [W-1:0] eq, input logic eco);
        total++;
        if (q !== eq || qbar !== ~eq || sout_l !== eq[W-1] || sout_r !== eq[0] || co !== eco) begin
            bad++;
            $display("FAIL %s: got q=%b qbar=%b sout_l=%b sout_r=%b co=%b, want q=%b qbar=%b sout_l=%b sout_r=%b co=%b",
                     name, q, qbar, sout_l, sout_r, co, eq, ~eq, eq[W-1], eq[0], eco);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] m,
                         input logic [W-1:0] dd, input logic sr, input logic sl);
        rst = r; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: integer arithmetic modulo 2^W.
    task automatic model_step(input logic r, input logic e, input logic [2:0] m,
                              input logic [W-1:0] dd, input logic sr, input logic sl);
        int top;
        int nq;
        int nco;
        top = 1 << W;
        nq  = mq;
        nco = 0;
        if (r) begin
            nq = 0;
        end else if (e) begin
            case (int'(m))
                1: nq = int'(dd);
                2: nq = (mq * 2 + int'(sr)) % top;
                3: nq = mq / 2 + int'(sl) * (top / 2);
                4: nq = (mq * 2) % top + mq / (top / 2);
                5: nq = mq / 2 + (mq % 2) * (top / 2);
                6: begin nq = (mq + 1) % top;       nco = (mq == top - 1) ? 1 : 0; end
                7: begin nq = (mq + top - 1) % top; nco = (mq == 0) ? 1 : 0;       end
                default: nq = mq;
            endcase
        end
        mq  = nq;
        mco = nco;
    endtask

    initial begin
        logic         r, e, sr, sl;
        logic [2:0]   m;
        logic [W-1:0] dd;

        rst = 1'b0; en = 1'b0; mode = 3'd0; d = '0; sin_r = 1'b0; sin_l = 1'b0;

        // Reset with a competing load.
        vecs.push_back('{1'b1, 1'b1, 3'd1, 4'b1010, 1'b0, 1'b0, 4'b0000, 1'b0});
        // Load then shift.
        vecs.push_back('{1'b0, 1'b1, 3'd1, 4'b1011, 1'b0, 1'b0, 4'b1011, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd2, 4'b0000, 1'b0, 1'b0, 4'b0110, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 4'b0000, 1'b0, 1'b1, 4'b1011, 1'b0});
        // Rotate left four times, then right four times.
        vecs.push_back('{1'b0, 1'b1, 3'd1, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0});
        // Rotate ignores serial inputs.
        vecs.push_back('{1'b0, 1'b1, 3'd1, 4'b0110, 1'b0, 1'b0, 4'b0110, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 4'b0000, 1'b1, 1'b1, 4'b1100, 1'b0});
        // Count wrap up, then down.
        vecs.push_back('{1'b0, 1'b1, 3'd1, 4'b1110, 1'b0, 1'b0, 4'b1110, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd7, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd7, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0});
        // Enable low holds regardless of mode and data.
        vecs.push_back('{1'b0, 1'b1, 3'd1, 4'b0101, 1'b0, 1'b0, 4'b0101, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'd1, 4'b1111, 1'b1, 1'b1, 4'b0101, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'd2, 4'b1111, 1'b1, 1'b1, 4'b0101, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b1, 4'b0101, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 4'b1111, 1'b0, 1'b0, 4'b1111, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0});
        // Reset mid-count, then resume counting from zero.
        vecs.push_back('{1'b0, 1'b1, 3'd1, 4'b0011, 1'b0, 1'b0, 4'b0011, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0});
        // Reset beats a wrapping count.
        vecs.push_back('{1'b0, 1'b1, 3'd1, 4'b1111, 1'b0, 1'b0, 4'b1111, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd6, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin_r, vecs[i].sin_l);
            check($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_co);
        end

        // Reset pulse between edges must not clear q.
        drive(1'b0, 1'b1, 3'd1, 4'b1001, 1'b0, 1'b0);
        check("load_before_pulse", 4'b1001, 1'b0);
        en = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_no_edge", 4'b1001, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0);
        check("hold_after_pulse", 4'b1001, 1'b0);

        // Randomized traffic against the model.
        drive(1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
        mq = 0;
        mco = 0;
        check("rand_reset", 4'b0000, 1'b0);
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 24) == 0);
            e  = ($urandom_range(0, 7) != 0);
            m  = 3'($urandom_range(0, 7));
            dd = W'($urandom_range(0, (1 << W) - 1));
            sr = 1'($urandom_range(0, 1));
            sl = 1'($urandom_range(0, 1));
            if (k % 40 < 12) m = 3'd6 + 3'($urandom_range(0, 1));
            model_step(r, e, m, dd, sr, sl);
            drive(r, e, m, dd, sr, sl);
            check($sformatf("rand%0d_m%0d", k, m), W'(mq), mco[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
